// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed serial transmitter (start 0, data MSB-first, optional even parity, stop 1).
// Define SERIAL_FRAME_TX_PARITY_EN to insert the even-parity bit between the data bits and STOP.
module serial_frame_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             x_out,
    output logic             busy,
    output logic             ready,
    output logic             done,
    output logic [2:0]       state_out
);
    localparam logic [2:0] IDLE  = 3'b000;
    localparam logic [2:0] START = 3'b001;
    localparam logic [2:0] DATA  = 3'b010;
    localparam logic [2:0] STOP  = 3'b100;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam logic [2:0] PARITY     = 3'b011;
    localparam logic [2:0] AFTER_DATA = PARITY;
    logic par_q, par_d;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [4:0]       bit_q, bit_d;
    logic [7:0]       cyc_q, cyc_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign bit_end = cyc_q == 8'(BIT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        cyc_d   = bit_end ? 8'd0 : cyc_q + 8'd1;
        done_d  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cyc_d = 8'd0;
                if (load) begin
                    shreg_d = data_in;
                    bit_d   = 5'd0;
                    state_d = START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            START: state_d = bit_end ? DATA : START;
            DATA: begin
                if (bit_end) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_d   = bit_q + 5'd1;
                    state_d = (bit_q == 5'(WIDTH - 1)) ? AFTER_DATA : DATA;
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: state_d = bit_end ? STOP : PARITY;
`endif
            STOP: begin
                state_d = bit_end ? IDLE : STOP;
                done_d  = bit_end;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Line level is decoded from registered state only, so reset forces it high without an edge.
    always_comb begin
        x_out = 1'b1;
        case (state_q)
            START: x_out = 1'b0;
            DATA:  x_out = shreg_q[WIDTH-1];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: x_out = par_q;
`endif
            default: x_out = 1'b1;
        endcase
    end

    assign busy      = state_q != IDLE;
    assign ready     = !busy;
    assign done      = done_q;
    assign state_out = state_q;
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Moore-style serial frame transmitter. It accepts a parallel word through a load handshake and drives it onto a single-bit line as a framed serial stream: an idle-high line, a zero start bit, data MSB-first, an optional parity bit, and a one stop bit. It is the driving end for the zero-detecting serial receivers in this design. It generates the `x_in` stimulus those FSMs consume, and all of its outputs are decoded from registered state only.

## Interface
- `WIDTH`, default 8: data word width; legal range 2..16.
- `BIT_CYCLES`, default 4: clock cycles per serial bit; legal range 1..255.

- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `load` input 1: request to send `data_in`; sampled on the rising edge of `clock`.
- `data_in` input WIDTH: word to transmit; captured only when `load` is accepted.
- `x_out` output 1: serial line.
- `busy` output 1: high while a frame is in flight.
- `ready` output 1: the inverse of `busy`.
- `done` output 1: one-cycle pulse at the end of a frame.
- `state_out` output 3: current FSM state encoding, for debug and observation.

## Operation
- States and encodings:
  - IDLE = 3'b000
  - START = 3'b001
  - DATA = 3'b010
  - PARITY = 3'b011
  - STOP = 3'b100
  - Codes 101..111 are illegal and go to IDLE on the next edge.
- `x_out` by state, as a pure function of state and the shift register:
  - IDLE: 1
  - START: 0
  - DATA: `shreg[WIDTH-1]`
  - PARITY: the even parity of the captured word
  - STOP: 1
- `busy` is 1 in every state except IDLE.
- Accepting a load:
  - A load is accepted when the FSM is in IDLE and `load` is 1 at a rising edge.
  - On that edge: `shreg` takes `data_in`, the parity register takes the XOR-reduction of `data_in`, the bit counter clears, the cycle counter clears, and the state goes to START.
- Bit timing:
  - The cycle counter counts 0..BIT_CYCLES-1.
  - Every state except IDLE holds for exactly BIT_CYCLES clocks.
  - The state advances on the edge where the cycle counter equals BIT_CYCLES-1.
- Transitions:
  - START → DATA.
  - DATA: at each bit end, `shreg` shifts left by one with zero fill and the bit counter increments. After WIDTH bits, DATA goes to PARITY if parity is compiled in, otherwise to STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- `done`:
  - Registered; it is 1 for exactly the first cycle after STOP → IDLE and 0 otherwise.
  - A `load` in that cycle is accepted, so frames can run back-to-back.
- `load` while `busy` is ignored; `data_in` changes while busy have no effect.
- `state_out` always equals the state register.

## Timing
- Reset values, applied asynchronously on `reset`=0:
  - state = IDLE
  - `x_out` = 1
  - `busy` = 0
  - `ready` = 1
  - `done` = 0
  - `state_out` = 3'b000
  - `shreg`, parity register and both counters = 0
- Reset mid-frame aborts the frame immediately, with no edge required: `x_out` returns to 1 and no `done` pulse is produced.
- Load to line latency: for a load accepted at edge k, `x_out` falls to 0 in the cycle after edge k, with no extra pipeline stage.
- Frame length: (WIDTH + 2 + P) × BIT_CYCLES cycles, where P = 1 with parity compiled in and P = 0 without.
- `done` asserts in the cycle after the last STOP cycle.
- Minimum load-to-load period: frame length + 1 cycle. The extra cycle is the IDLE cycle that carries `done`.
- With BIT_CYCLES = 1, each bit lasts one cycle and the cycle counter stays at 0.

## Configuration
- `SERIAL_FRAME_TX_PARITY_EN`
  - Defined: the PARITY state is present and one even-parity bit is sent between the last data bit and STOP. The parity bit equals the XOR of all data bits.
  - Undefined: DATA goes directly to STOP, and encoding 3'b011 is treated as illegal (it goes to IDLE).

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release → `x_out`=1, `busy`=0, `ready`=1, `done`=0, `state_out`=000; all stay unchanged with `load`=0 for 20 cycles.
- Basic frame, WIDTH=8, BIT_CYCLES=4, parity off: load `data_in`=8'hA5 → `x_out` runs 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; `done` pulses in cycle 41 after the load edge.
- Parity on: load 8'h07 → parity bit 1 is sent after the data bits; load 8'hA5 → parity bit 0; frame length is 44 cycles.
- Load ignored while busy: pulse `load` with 8'hFF at cycle 10 of an 8'h00 frame → the line still carries eight 0 data bits, and there is exactly one `done`.
- Back-to-back: hold `load`=1 continuously with alternating words → frames are separated by exactly one idle-high cycle, and each `done` coincides with acceptance of the next word.
- Reset mid-DATA: assert `reset`=0 asynchronously during bit 3 → `x_out`=1 and `state_out`=000 before the next edge, with no `done`; a load after release sends a full, correct frame.
